// File: rtl/register_file.sv
// rtl/register_file.sv - 16 x 16-bit register file, two read ports, one write port
//
// Purpose:
//   Operand store for the CPU datapath. Reads are combinational and writes
//   commit on the rising edge of clk. Storage clears asynchronously while
//   rst is low.
//
// Ports:
//   clk     in   1  clock; writes commit on the rising edge
//   rst     in   1  asynchronous reset, active low
//   re_0    in   1  port 0 read enable, active low (0 = read)
//   raddr0  in   4  port 0 read address
//   re_1    in   1  port 1 read enable, active low (0 = read)
//   raddr1  in   4  port 1 read address
//   we      in   1  write enable, active low (0 = write)
//   waddr   in   4  write address
//   wdata   in  16  write data
//   rdata0  out 16  port 0 read data (0x0000 when disabled)
//   rdata1  out 16  port 1 read data (0x0000 when disabled)
//
// Build option:
//   REGFILE_BYPASS_EN - when defined, an enabled read of the entry being
//   written in the same cycle returns wdata instead of the stored value.
//   When undefined, reads always return stored contents.

`timescale 1ns/1ps

module register_file (
  input  logic        clk,
  input  logic        rst,
  input  logic        re_0,
  input  logic [3:0]  raddr0,
  input  logic        re_1,
  input  logic [3:0]  raddr1,
  input  logic        we,
  input  logic [3:0]  waddr,
  input  logic [15:0] wdata,
  output logic [15:0] rdata0,
  output logic [15:0] rdata1
);

  logic [15:0] regs [16];

  // Entry 0 is ordinary storage; no hardwired zero register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 16; i++) begin
        regs[i] <= 16'h0000;
      end
    end else if (!we) begin
      regs[waddr] <= wdata;
    end
  end

  // Forwarding hit per port. Qualified by rst so a held-off write during
  // reset never leaks onto a read port.
  logic byp0;
  logic byp1;

`ifdef REGFILE_BYPASS_EN
  assign byp0 = !we && rst && (raddr0 == waddr);
  assign byp1 = !we && rst && (raddr1 == waddr);
`else
  assign byp0 = 1'b0;
  assign byp1 = 1'b0;
`endif

  // Storage already reads as zero during reset; the rst gate keeps the
  // outputs at zero regardless of how the storage is implemented.
  always_comb begin
    rdata0 = 16'h0000;
    if (!re_0) begin
      if (byp0) begin
        rdata0 = wdata;
      end else if (rst) begin
        rdata0 = regs[raddr0];
      end
    end
  end

  always_comb begin
    rdata1 = 16'h0000;
    if (!re_1) begin
      if (byp1) begin
        rdata1 = wdata;
      end else if (rst) begin
        rdata1 = regs[raddr1];
      end
    end
  end

endmodule

// File: tb/tb_register_file.sv
// tb/tb_register_file.sv - self-checking bench for register_file

`timescale 1ns/1ps

module tb_register_file;

  logic        clk;
  logic        rst;
  logic        re_0;
  logic [3:0]  raddr0;
  logic        re_1;
  logic [3:0]  raddr1;
  logic        we;
  logic [3:0]  waddr;
  logic [15:0] wdata;
  logic [15:0] rdata0;
  logic [15:0] rdata1;

  int n_checks = 0;
  int n_errors = 0;

  // Reference contents: plain array updated from the behavioural rules.
  logic [15:0] model [16];

  register_file dut (
    .clk    (clk),
    .rst    (rst),
    .re_0   (re_0),
    .raddr0 (raddr0),
    .re_1   (re_1),
    .raddr1 (raddr1),
    .we     (we),
    .waddr  (waddr),
    .wdata  (wdata),
    .rdata0 (rdata0),
    .rdata1 (rdata1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] expect_read(input logic re, input logic [3:0] ra);
    logic [15:0] v;
    v = 16'h0000;
    if (!re) begin
      if (!rst) v = 16'h0000;
`ifdef REGFILE_BYPASS_EN
      else if (!we && ra == waddr) v = wdata;
`endif
      else v = model[ra];
    end
    return v;
  endfunction

  task automatic clear_model();
    for (int i = 0; i < 16; i++) model[i] = 16'h0000;
  endtask

  // Drive reset level; asserting it empties the model at once.
  task automatic set_rst(input logic v);
    rst = v;
    if (!v) clear_model();
  endtask

  task automatic check_ports(input string tag);
    #1;
    check_eq({tag, "/rd0"}, rdata0, expect_read(re_0, raddr0));
    check_eq({tag, "/rd1"}, rdata1, expect_read(re_1, raddr1));
  endtask

  // One rising edge; inputs are stable across it. Leaves time 2ns past the edge.
  task automatic tick();
    @(posedge clk);
    if (rst && !we) model[waddr] = wdata;
    #2;
  endtask

  initial begin
    clear_model();
    rst = 1'b0; re_0 = 1'b0; re_1 = 1'b0; raddr0 = 4'd1; raddr1 = 4'd2;
    we = 1'b0; waddr = 4'd1; wdata = 16'hFFFF;
    #2;
    // Reset holds outputs at zero and blocks the write.
    check_eq("reset/rd0", rdata0, 16'h0000);
    check_eq("reset/rd1", rdata1, 16'h0000);
    tick();
    check_ports("reset_write_blocked");

    // Basic write/read.
    set_rst(1'b1);
    we = 1'b1;
    check_eq("after_reset/rd0", rdata0, 16'h0000);
    we = 1'b0; waddr = 4'd3; wdata = 16'h0001;
    tick();
    we = 1'b1; raddr0 = 4'd3; raddr1 = 4'd0;
    #1;
    check_eq("basic/rd0", rdata0, 16'h0001);
    check_eq("basic/rd1", rdata1, 16'h0000);

    // Read disable.
    re_0 = 1'b1;
    #1 check_eq("disable/rd0", rdata0, 16'h0000);
    re_0 = 1'b0;
    #1 check_eq("reenable/rd0", rdata0, 16'h0001);

    // Same-cycle write and read of entry 4.
    we = 1'b0; waddr = 4'd4; wdata = 16'h0008; raddr0 = 4'd4; raddr1 = 4'd3;
    #1;
`ifdef REGFILE_BYPASS_EN
    check_eq("same_cycle_pre/rd0", rdata0, 16'h0008);
`else
    check_eq("same_cycle_pre/rd0", rdata0, 16'h0000);
`endif
    check_eq("same_cycle_pre/rd1", rdata1, 16'h0001);
    tick();
    we = 1'b1;
    #1;
    check_eq("same_cycle_post/rd0", rdata0, 16'h0008);
    check_eq("same_cycle_post/rd1", rdata1, 16'h0001);

    // Overwrite and dual read.
    we = 1'b0; waddr = 4'd3; wdata = 16'h0003;
    tick();
    we = 1'b1; raddr0 = 4'd4; raddr1 = 4'd3;
    #1;
    check_eq("overwrite/rd0", rdata0, 16'h0008);
    check_eq("overwrite/rd1", rdata1, 16'h0003);

    // Both ports on the same entry.
    raddr0 = 4'd3;
    #1 check_eq("same_addr/rd0", rdata0, 16'h0003);
    check_eq("same_addr/rd1", rdata1, 16'h0003);

    // Entry 0 is writable.
    we = 1'b0; waddr = 4'd0; wdata = 16'hBEEF;
    tick();
    we = 1'b1; raddr0 = 4'd0;
    #1 check_eq("entry0/rd0", rdata0, 16'hBEEF);

    // Asynchronous reset between edges.
    raddr0 = 4'd4; raddr1 = 4'd3;
    @(negedge clk);
    #1;
    set_rst(1'b0);
    #1;
    check_eq("async_reset/rd0", rdata0, 16'h0000);
    check_eq("async_reset/rd1", rdata1, 16'h0000);
    tick();
    set_rst(1'b1);
    check_ports("after_async_reset");

    // Randomised traffic against the model.
    for (int cyc = 0; cyc < 400; cyc++) begin
      re_0   = ($urandom_range(0, 7) == 0);
      re_1   = ($urandom_range(0, 7) == 0);
      we     = ($urandom_range(0, 3) == 0);
      waddr  = 4'($urandom_range(0, 15));
      wdata  = 16'($urandom);
      raddr0 = ($urandom_range(0, 3) == 0) ? waddr : 4'($urandom_range(0, 15));
      raddr1 = ($urandom_range(0, 3) == 0) ? waddr : 4'($urandom_range(0, 15));
      if (!rst) set_rst(1'b1);
      else if ($urandom_range(0, 49) == 0) set_rst(1'b0);
      check_ports("rand_pre");
      tick();
      check_ports("rand_post");
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
